idp_sequencer: RTL and testbench

//  Command-driven controller that sequences Integer_Datapath over multiple cycles: bulk

---
 rtl/idp_pkg.sv | 40 ++++
 rtl/idp_sequencer.sv | 240 ++++++++++++++++++++++++
 tb/tb_idp_sequencer.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/idp_pkg.sv
`default_nettype none
// ============================================================================
// Module  : idp_pkg
// Brief   : Opcodes, FSM state codes and datapath control constants shared by
//           the integer-datapath sequencer.
// Rev     : 1.0
// ============================================================================
package idp_pkg;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_DUMP = 2'b01,
        OP_ALU  = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LOAD     = 3'd1;
    localparam logic [2:0] ST_DUMP_RD  = 3'd2;
    localparam logic [2:0] ST_DUMP_OUT = 3'd3;
    localparam logic [2:0] ST_ALU_EXE  = 3'd4;
    localparam logic [2:0] ST_FIN      = 3'd5;

    localparam logic [4:0] FS_PASS_S = 5'h00;
    localparam logic [4:0] FS_PASS_T = 5'h01;
    localparam logic [4:0] FS_ADD    = 5'h02;
    localparam logic [4:0] FS_MUL    = 5'h1E;
    localparam logic [4:0] FS_DIV    = 5'h1F;

    localparam logic [2:0] YSEL_ALU = 3'b010;

    // Multiply and divide produce a 64-bit result that lands in HI/LO.
    function automatic logic fs_uses_hilo(input logic [4:0] fs);
        return (fs == FS_MUL) || (fs == FS_DIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/idp_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : idp_sequencer
// Brief   : Handshaked command FSM driving Integer_Datapath for bulk register
//           load, paired S/T register dump and single ALU op with writeback.
// Rev     : 1.0
// ============================================================================
module idp_sequencer
    import idp_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int AW     = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [4:0]        cmd_fs,
    input  logic [AW-1:0]     cmd_s,
    input  logic [AW-1:0]     cmd_t,
    input  logic [AW-1:0]     cmd_d,
    input  logic [AW-1:0]     cmd_cnt,
    output logic [AW-1:0]     mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              D_En,
    output logic              T_Sel,
    output logic              HILO_ld,
    output logic [AW-1:0]     D_Addr,
    output logic [AW-1:0]     S_Addr,
    output logic [AW-1:0]     T_Addr,
    output logic [4:0]        FS,
    output logic [2:0]        Y_Sel,
    output logic [DATA_W-1:0] DT,
    input  logic [DATA_W-1:0] ALU_OUT,
    input  logic [DATA_W-1:0] D_OUT,
    input  logic              C,
    input  logic              V,
    input  logic              N,
    input  logic              Z,
    output logic              dmp_valid,
    input  logic              dmp_ready,
    output logic [AW-1:0]     dmp_s_addr,
    output logic [AW-1:0]     dmp_t_addr,
    output logic [DATA_W-1:0] dmp_s_data,
    output logic [DATA_W-1:0] dmp_t_data,
    output logic [3:0]        flags,
    output logic              done,
    output logic              err
);

    state_t              r_state;
    logic [AW-1:0]       r_s, r_t, r_d, r_cnt, r_idx;
    logic                r_d_en, r_t_sel, r_hilo_ld, r_dt_pass;
    logic [AW-1:0]       r_mem_addr, r_d_addr, r_s_addr, r_t_addr;
    logic [4:0]          r_fs;
    logic [2:0]          r_y_sel;
    logic                r_dmp_valid;
    logic [AW-1:0]       r_dmp_s_addr, r_dmp_t_addr;
    logic [DATA_W-1:0]   r_dmp_s_data, r_dmp_t_data;
    logic [3:0]          r_flags;
    logic                r_done, r_err;

    logic [AW-1:0]       w_idx_nxt;
    logic                w_last;

    assign w_idx_nxt = r_idx + 1'b1;
    assign w_last    = (r_idx == r_cnt - 1'b1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_s          <= '0;
            r_t          <= '0;
            r_d          <= '0;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_d_en       <= 1'b0;
            r_t_sel      <= 1'b0;
            r_hilo_ld    <= 1'b0;
            r_dt_pass    <= 1'b0;
            r_mem_addr   <= '0;
            r_d_addr     <= '0;
            r_s_addr     <= '0;
            r_t_addr     <= '0;
            r_fs         <= '0;
            r_y_sel      <= '0;
            r_dmp_valid  <= 1'b0;
            r_dmp_s_addr <= '0;
            r_dmp_t_addr <= '0;
            r_dmp_s_data <= '0;
            r_dmp_t_data <= '0;
            r_flags      <= '0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            // Control strobes fall to zero unless the next state re-asserts them.
            r_d_en     <= 1'b0;
            r_t_sel    <= 1'b0;
            r_hilo_ld  <= 1'b0;
            r_dt_pass  <= 1'b0;
            r_mem_addr <= '0;
            r_d_addr   <= '0;
            r_s_addr   <= '0;
            r_t_addr   <= '0;
            r_fs       <= '0;
            r_y_sel    <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_s   <= cmd_s;
                        r_t   <= cmd_t;
                        r_d   <= cmd_d;
                        r_cnt <= cmd_cnt;
                        r_idx <= '0;
                        case (cmd_op)
                            OP_LOAD: begin
                                if (cmd_cnt == '0) begin
                                    r_state <= ST_FIN;
                                    r_done  <= 1'b1;
                                end else begin
                                    r_state   <= ST_LOAD;
                                    r_d_en    <= 1'b1;
                                    r_dt_pass <= 1'b1;
                                    r_fs      <= FS_PASS_T;
                                    r_y_sel   <= YSEL_ALU;
                                    r_d_addr  <= cmd_d;
                                end
                            end
                            OP_DUMP: begin
                                if (cmd_cnt == '0) begin
                                    r_state <= ST_FIN;
                                    r_done  <= 1'b1;
                                end else begin
                                    r_state  <= ST_DUMP_RD;
                                    r_s_addr <= cmd_s;
                                    r_t_addr <= cmd_t;
                                    r_fs     <= FS_PASS_S;
                                    r_t_sel  <= 1'b1;
                                    r_y_sel  <= YSEL_ALU;
                                end
                            end
                            OP_ALU: begin
                                r_state   <= ST_ALU_EXE;
                                r_s_addr  <= cmd_s;
                                r_t_addr  <= cmd_t;
                                r_fs      <= cmd_fs;
                                r_y_sel   <= YSEL_ALU;
                                r_d_addr  <= cmd_d;
                                r_d_en    <= 1'b1;
                                r_hilo_ld <= fs_uses_hilo(cmd_fs);
                            end
                            default: begin
                                r_state <= ST_FIN;
                                r_done  <= 1'b1;
                                r_err   <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_LOAD: begin
                    if (w_last) begin
                        r_state <= ST_FIN;
                        r_done  <= 1'b1;
                    end else begin
                        r_idx      <= w_idx_nxt;
                        r_mem_addr <= w_idx_nxt;
                        r_d_addr   <= r_d + w_idx_nxt;
                        r_d_en     <= 1'b1;
                        r_dt_pass  <= 1'b1;
                        r_fs       <= FS_PASS_T;
                        r_y_sel    <= YSEL_ALU;
                    end
                end
                ST_DUMP_RD: begin
                    r_dmp_s_data <= ALU_OUT;
                    r_dmp_t_data <= D_OUT;
                    r_dmp_s_addr <= r_s + r_idx;
                    r_dmp_t_addr <= r_t + r_idx;
                    r_dmp_valid  <= 1'b1;
                    r_state      <= ST_DUMP_OUT;
                end
                ST_DUMP_OUT: begin
                    if (dmp_ready) begin
                        r_dmp_valid <= 1'b0;
                        if (w_last) begin
                            r_state <= ST_FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx    <= w_idx_nxt;
                            r_state  <= ST_DUMP_RD;
                            r_s_addr <= r_s + w_idx_nxt;
                            r_t_addr <= r_t + w_idx_nxt;
                            r_fs     <= FS_PASS_S;
                            r_t_sel  <= 1'b1;
                            r_y_sel  <= YSEL_ALU;
                        end
                    end
                end
                ST_ALU_EXE: begin
                    r_flags <= {C, V, N, Z};
                    r_state <= ST_FIN;
                    r_done  <= 1'b1;
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Gated with reset so the port reads 0 while reset is held.
    assign cmd_ready  = (r_state == ST_IDLE) && reset;
    assign mem_addr   = r_mem_addr;
    assign DT         = r_dt_pass ? mem_rdata : '0;
    assign D_En       = r_d_en;
    assign T_Sel      = r_t_sel;
    assign HILO_ld    = r_hilo_ld;
    assign D_Addr     = r_d_addr;
    assign S_Addr     = r_s_addr;
    assign T_Addr     = r_t_addr;
    assign FS         = r_fs;
    assign Y_Sel      = r_y_sel;
    assign dmp_valid  = r_dmp_valid;
    assign dmp_s_addr = r_dmp_s_addr;
    assign dmp_t_addr = r_dmp_t_addr;
    assign dmp_s_data = r_dmp_s_data;
    assign dmp_t_data = r_dmp_t_data;
    assign flags      = r_flags;
    assign done       = r_done;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_idp_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_idp_sequencer
// Brief   : Scoreboard bench for idp_sequencer with a small datapath stand-in.
// Rev     : 1.0
// ============================================================================
module tb_idp_sequencer;
    import idp_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_fs, cmd_s, cmd_t, cmd_d, cmd_cnt;
    logic [4:0]  mem_addr;
    logic [31:0] mem_rdata;
    logic        D_En, T_Sel, HILO_ld;
    logic [4:0]  D_Addr, S_Addr, T_Addr, FS;
    logic [2:0]  Y_Sel;
    logic [31:0] DT, ALU_OUT, D_OUT;
    logic        C, V, N, Z;
    logic        dmp_valid, dmp_ready;
    logic [4:0]  dmp_s_addr, dmp_t_addr;
    logic [31:0] dmp_s_data, dmp_t_data;
    logic [3:0]  flags;
    logic        done, err;

    logic [31:0] img    [32];
    logic [31:0] rf     [32];
    logic [31:0] exp_rf [32];

    typedef struct {
        logic [4:0]  addr;
        logic [4:0]  fs;
        logic        hilo;
        logic        is_load;
        logic [4:0]  maddr;
        logic [31:0] dt;
        logic [4:0]  s;
        logic [4:0]  t;
        int          cyc;
    } wr_t;
    typedef struct {
        logic [4:0]  sa;
        logic [4:0]  ta;
        logic [31:0] sd;
        logic [31:0] td;
    } beat_t;
    typedef struct {
        logic       err;
        logic       chk_flags;
        logic [3:0] flags;
        int         cyc;
    } done_t;

    wr_t   wq[$];
    beat_t bq[$];
    done_t dq[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int dump_hs = 0;

    idp_sequencer #(.DATA_W(32), .AW(5)) u_dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_fs(cmd_fs),
        .cmd_s(cmd_s), .cmd_t(cmd_t), .cmd_d(cmd_d), .cmd_cnt(cmd_cnt),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .D_En(D_En), .T_Sel(T_Sel), .HILO_ld(HILO_ld),
        .D_Addr(D_Addr), .S_Addr(S_Addr), .T_Addr(T_Addr),
        .FS(FS), .Y_Sel(Y_Sel), .DT(DT),
        .ALU_OUT(ALU_OUT), .D_OUT(D_OUT), .C(C), .V(V), .N(N), .Z(Z),
        .dmp_valid(dmp_valid), .dmp_ready(dmp_ready),
        .dmp_s_addr(dmp_s_addr), .dmp_t_addr(dmp_t_addr),
        .dmp_s_data(dmp_s_data), .dmp_t_data(dmp_t_data),
        .flags(flags), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign mem_rdata = img[mem_addr];

    // Datapath stand-in: register file plus the few ALU functions exercised here.
    always_comb begin
        ALU_OUT = '0;
        C       = 1'b0;
        V       = 1'b0;
        case (FS)
            FS_PASS_S: ALU_OUT = rf[S_Addr];
            FS_PASS_T: ALU_OUT = DT;
            FS_ADD: begin
                {C, ALU_OUT} = {1'b0, rf[S_Addr]} + {1'b0, rf[T_Addr]};
                V = (rf[S_Addr][31] == rf[T_Addr][31]) && (ALU_OUT[31] != rf[S_Addr][31]);
            end
            FS_MUL:  ALU_OUT = rf[S_Addr] * rf[T_Addr];
            FS_DIV:  ALU_OUT = (rf[T_Addr] != 0) ? rf[S_Addr] / rf[T_Addr] : '0;
            default: ALU_OUT = '0;
        endcase
    end
    assign N     = ALU_OUT[31];
    assign Z     = (ALU_OUT == '0);
    assign D_OUT = rf[T_Addr];

    always @(posedge clk) begin
        if (D_En && Y_Sel == YSEL_ALU) rf[D_Addr] <= ALU_OUT;
    end

    logic [144:0] all_outs;
    assign all_outs = {cmd_ready, mem_addr, D_En, T_Sel, HILO_ld, D_Addr, S_Addr, T_Addr,
                       FS, Y_Sel, DT, dmp_valid, dmp_s_addr, dmp_t_addr, dmp_s_data,
                       dmp_t_data, flags, done, err};

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Write / done monitor
    wr_t   m_w;
    done_t m_d;
    always @(negedge clk) begin
        if (reset) begin
            if (D_En) begin
                if (wq.size() == 0) begin
                    check("wr_unexpected_D_En", D_En, 1'b0);
                end else begin
                    m_w = wq.pop_front();
                    check("wr_ctrl", {D_Addr, FS, T_Sel, Y_Sel, HILO_ld},
                          {m_w.addr, m_w.fs, 1'b0, YSEL_ALU, m_w.hilo});
                    check("wr_cycle", cyc, m_w.cyc);
                    if (m_w.is_load) check("wr_load_data", {mem_addr, DT}, {m_w.maddr, m_w.dt});
                    else             check("wr_alu_regs", {S_Addr, T_Addr}, {m_w.s, m_w.t});
                end
            end
            if (done) begin
                if (dq.size() == 0) begin
                    check("done_unexpected", done, 1'b0);
                end else begin
                    m_d = dq.pop_front();
                    check("done_err", err, m_d.err);
                    if (m_d.cyc >= 0)  check("done_cycle", cyc, m_d.cyc);
                    if (m_d.chk_flags) check("flags", flags, m_d.flags);
                end
            end
        end
    end

    // Dump stream monitor
    beat_t       m_b;
    logic        prev_stall = 1'b0;
    logic [73:0] held;
    always @(negedge clk) begin
        if (reset) begin
            if (prev_stall) begin
                check("dmp_hold_valid", dmp_valid, 1'b1);
                check("dmp_hold_payload", {dmp_s_addr, dmp_t_addr, dmp_s_data, dmp_t_data}, held);
            end
            prev_stall = dmp_valid && !dmp_ready;
            held       = {dmp_s_addr, dmp_t_addr, dmp_s_data, dmp_t_data};
            if (dmp_valid && dmp_ready) begin
                dump_hs++;
                if (bq.size() == 0) begin
                    check("dmp_unexpected", dmp_valid, 1'b0);
                end else begin
                    m_b = bq.pop_front();
                    check("dmp_beat", {dmp_s_addr, dmp_t_addr, dmp_s_data, dmp_t_data},
                          {m_b.sa, m_b.ta, m_b.sd, m_b.td});
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!cmd_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_wait", cmd_ready, 1'b1);
    endtask

    task automatic issue(input logic [1:0] op, input logic [4:0] fs, input logic [4:0] s,
                         input logic [4:0] t, input logic [4:0] d, input logic [4:0] cnt,
                         output int acc);
        wait_idle();
        cmd_op = op; cmd_fs = fs; cmd_s = s; cmd_t = t; cmd_d = d; cmd_cnt = cnt;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        acc = cyc;
    endtask

    task automatic do_load(input logic [4:0] d, input logic [4:0] cnt);
        int acc;
        wr_t w;
        done_t dn;
        issue(OP_LOAD, 5'h00, 5'h00, 5'h00, d, cnt, acc);
        for (int i = 0; i < int'(cnt); i++) begin
            w.addr = 5'(int'(d) + i); w.fs = FS_PASS_T; w.hilo = 1'b0; w.is_load = 1'b1;
            w.maddr = 5'(i); w.dt = img[i]; w.s = '0; w.t = '0; w.cyc = acc + i;
            wq.push_back(w);
            exp_rf[w.addr] = img[i];
        end
        dn.err = 1'b0; dn.chk_flags = 1'b0; dn.flags = '0; dn.cyc = acc + int'(cnt);
        dq.push_back(dn);
    endtask

    task automatic do_alu(input logic [4:0] fs, input logic [4:0] s, input logic [4:0] t,
                          input logic [4:0] d, input logic hilo, input logic [3:0] exp_flags,
                          input logic [31:0] exp_res);
        int acc;
        wr_t w;
        done_t dn;
        issue(OP_ALU, fs, s, t, d, 5'h00, acc);
        w.addr = d; w.fs = fs; w.hilo = hilo; w.is_load = 1'b0; w.maddr = '0; w.dt = '0;
        w.s = s; w.t = t; w.cyc = acc;
        wq.push_back(w);
        exp_rf[d] = exp_res;
        dn.err = 1'b0; dn.chk_flags = 1'b1; dn.flags = exp_flags; dn.cyc = acc + 1;
        dq.push_back(dn);
    endtask

    task automatic do_dump(input logic [4:0] s, input logic [4:0] t, input logic [4:0] cnt);
        int acc;
        beat_t b;
        done_t dn;
        issue(OP_DUMP, 5'h00, s, t, 5'h00, cnt, acc);
        for (int i = 0; i < int'(cnt); i++) begin
            b.sa = 5'(int'(s) + i); b.ta = 5'(int'(t) + i);
            b.sd = exp_rf[b.sa];    b.td = exp_rf[b.ta];
            bq.push_back(b);
        end
        dn.err = 1'b0; dn.chk_flags = 1'b0; dn.flags = '0;
        dn.cyc = (cnt == 0) ? acc : -1;
        dq.push_back(dn);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int    acc;
        int    base;
        logic  found;
        done_t dn;

        reset = 1'b0; cmd_valid = 1'b0; dmp_ready = 1'b1;
        cmd_op = '0; cmd_fs = '0; cmd_s = '0; cmd_t = '0; cmd_d = '0; cmd_cnt = '0;
        for (int i = 0; i < 32; i++) begin
            img[i] = '0; exp_rf[i] = '0;
        end
        #12;
        check("reset_outputs", all_outs, '0);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("ready_after_reset", cmd_ready, 1'b1);
        @(posedge clk); #1;

        // Bulk loads: R0..15 and R16..31 from two distinct images
        for (int i = 0; i < 32; i++) img[i] = 32'hA500_0000 + 32'(i);
        do_load(5'd0, 5'd16);
        wait_idle();
        for (int i = 0; i < 32; i++) img[i] = 32'h5A00_0000 + 32'(i);
        do_load(5'd16, 5'd16);

        // Full-rate dump
        do_dump(5'd0, 5'd16, 5'd16);

        // Dump with a 5-cycle stall on beat 3
        do_dump(5'd0, 5'd16, 5'd8);
        base  = dump_hs;
        found = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            if (dmp_valid && dump_hs == base + 3) found = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        check("stall_window", found, 1'b1);
        dmp_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        dmp_ready = 1'b1;

        // ALU: signed overflow on add, HI/LO load on multiply
        wait_idle();
        img[0] = 32'h7FFF_FFFF;
        img[1] = 32'h0000_0001;
        do_load(5'd1, 5'd2);
        do_alu(FS_ADD, 5'd1, 5'd2, 5'd3, 1'b0, 4'b0110, 32'h8000_0000);
        do_alu(FS_MUL, 5'd1, 5'd2, 5'd4, 1'b1, 4'b0000, 32'h7FFF_FFFF);
        do_dump(5'd3, 5'd4, 5'd1);

        // Address wrap, zero-count and reserved opcode
        wait_idle();
        for (int i = 0; i < 32; i++) img[i] = 32'hC0DE_0000 + 32'(i);
        do_load(5'd30, 5'd4);
        do_dump(5'd30, 5'd2, 5'd4);
        do_load(5'd7, 5'd0);
        issue(OP_RSVD, 5'h00, 5'h00, 5'h00, 5'h00, 5'd3, acc);
        dn.err = 1'b1; dn.chk_flags = 1'b0; dn.flags = '0; dn.cyc = acc;
        dq.push_back(dn);
        do_dump(5'd5, 5'd5, 5'd0);

        // Asynchronous reset in the middle of a load
        wait_idle();
        for (int i = 0; i < 32; i++) img[i] = 32'hA500_0000 + 32'(i);
        do_load(5'd0, 5'd16);
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            if (D_En && D_Addr == 5'd5) found = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        check("reset_window", found, 1'b1);
        #1;
        reset = 1'b0;
        #1;
        check("reset_async_outputs", all_outs, '0);
        wq.delete();
        dq.delete();
        @(posedge clk); @(posedge clk); #1;
        check("reset_held_outputs", all_outs, '0);
        reset = 1'b1;
        #1;
        check("ready_after_abort", cmd_ready, 1'b1);
        @(posedge clk); #1;
        check("idle_after_abort", {cmd_ready, D_En, done}, 3'b100);

        repeat (4) @(posedge clk);
        #1;
        check("wr_queue_drained", wq.size(), 0);
        check("dmp_queue_drained", bq.size(), 0);
        check("done_queue_drained", dq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
